// File: rtl/cmp_pipe.sv
// Two-stage pipelined compare unit with valid/ready handshake and a saturating
// count of delivered true results.
module cmp_pipe #(
  parameter int unsigned N     = 10,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [2:0]       in_op,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_result,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned EXT_W = N + 1;

  localparam logic [2:0] OP_EQ = 3'b000;
  localparam logic [2:0] OP_NE = 3'b001;
  localparam logic [2:0] OP_LT = 3'b010;
  localparam logic [2:0] OP_GE = 3'b011;
  localparam logic [2:0] OP_GT = 3'b100;
  localparam logic [2:0] OP_LE = 3'b101;

  logic             s1_valid;
  logic             s1_eq;
  logic             s1_lt;
  logic [2:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;

  logic             accept_c;
  logic             deliver_c;
  logic             s2_load_c;
  logic [EXT_W-1:0] a_ext_c;
  logic [EXT_W-1:0] b_ext_c;
  logic [EXT_W-1:0] diff_c;
  logic             result_c;
  logic             err_c;

  // Handshake: S1 may refill in the same cycle it hands its entry to S2.
  always_comb begin
    deliver_c = out_valid & out_ready;
    s2_load_c = s1_valid & (~out_valid | out_ready);
    in_ready  = ~s1_valid | s2_load_c;
    accept_c  = in_valid & in_ready;
  end

  // One extra bit keeps the subtraction exact for both signed and unsigned.
  always_comb begin
    a_ext_c = {in_signed & in_a[N-1], in_a};
    b_ext_c = {in_signed & in_b[N-1], in_b};
    diff_c  = a_ext_c - b_ext_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_eq    <= 1'b0;
      s1_lt    <= 1'b0;
      s1_op    <= 3'b000;
      s1_tag   <= '0;
    end else if (accept_c) begin
      s1_valid <= 1'b1;
      s1_eq    <= (diff_c == '0);
      s1_lt    <= diff_c[N];
      s1_op    <= in_op;
      s1_tag   <= in_tag;
    end else if (s2_load_c) begin
      s1_valid <= 1'b0;
    end
  end

  // Relation decode from the registered equal / less-than flags.
  always_comb begin
    result_c = 1'b0;
    err_c    = 1'b0;
    case (s1_op)
      OP_EQ:   result_c = s1_eq;
      OP_NE:   result_c = ~s1_eq;
      OP_LT:   result_c = s1_lt;
      OP_GE:   result_c = ~s1_lt;
      OP_GT:   result_c = ~s1_lt & ~s1_eq;
      OP_LE:   result_c = s1_lt | s1_eq;
      default: err_c    = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= 1'b0;
      out_err    <= 1'b0;
      out_tag    <= '0;
    end else if (s2_load_c) begin
      out_valid  <= 1'b1;
      out_result <= result_c;
      out_err    <= err_c;
      out_tag    <= s1_tag;
    end else if (deliver_c) begin
      out_valid  <= 1'b0;
    end
  end

  // Clear wins over a coincident increment; count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (deliver_c && out_result && !(&match_cnt)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cmp_pipe.sv
// Bench for cmp_pipe: cycle-stepped stimulus checked against a queue-based
// reference of in-flight transactions.
module tb_cmp_pipe;

  localparam int unsigned N       = 10;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam int unsigned VW      = 4 + TAG_W + CNT_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic [2:0]       in_op;
  logic             in_signed;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic             out_result;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;
  logic             cnt_clr;
  logic [CNT_W-1:0] match_cnt;

  always #5 clk = ~clk;

  cmp_pipe #(.N(N), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err), .out_tag(out_tag),
    .cnt_clr(cnt_clr), .match_cnt(match_cnt)
  );

  typedef struct {
    logic             res;
    logic             err;
    logic [TAG_W-1:0] tag;
    int               k;
  } item_t;

  item_t          q[$];
  int             cyc = 0;
  int unsigned    cnt_m = 0;
  int             vec = 0;
  int             miscmp = 0;
  logic           exp_ready;
  logic           exp_valid;
  logic [VW-1:0]  exp_vec;
  logic [VW-1:0]  obs_vec;

  function automatic int sval(input logic [N-1:0] x, input logic sg);
    if (sg && x[N-1]) return int'(x) - (1 << N);
    return int'(x);
  endfunction

  // Reference comparison on plain integers.
  function automatic item_t ref_cmp(input logic [N-1:0] a, input logic [N-1:0] b,
                                    input logic [2:0] op, input logic sg,
                                    input logic [TAG_W-1:0] tag);
    item_t it;
    int va, vb;
    va = sval(a, sg);
    vb = sval(b, sg);
    it.err = 1'b0;
    it.tag = tag;
    it.k   = 0;
    case (op)
      3'd0: it.res = (va == vb);
      3'd1: it.res = (va != vb);
      3'd2: it.res = (va <  vb);
      3'd3: it.res = (va >= vb);
      3'd4: it.res = (va >  vb);
      3'd5: it.res = (va <= vb);
      default: begin it.res = 1'b0; it.err = 1'b1; end
    endcase
    return it;
  endfunction

  // Applies inputs just after the falling edge and forms expected/observed vectors.
  task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2:0] op, input logic sg, input logic [TAG_W-1:0] tag,
                       input logic ordy, input logic clr);
    item_t h;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    in_signed = sg;
    in_tag    = tag;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    h = '{res: 1'b0, err: 1'b0, tag: '0, k: 0};
    if (q.size() > 0) h = q[0];
    exp_ready = (q.size() < 2) || ordy;
    exp_valid = (q.size() > 0) && (cyc >= h.k + 1);
    exp_vec = {exp_ready, exp_valid,
               exp_valid ? {h.res, h.err, h.tag} : (2 + TAG_W)'(0),
               CNT_W'(cnt_m)};
    obs_vec = {in_ready, out_valid,
               out_valid ? {out_result, out_err, out_tag} : (2 + TAG_W)'(0),
               match_cnt};
  endtask

  task automatic idle(input logic ordy, input logic clr);
    drive(1'b0, '0, '0, 3'd0, 1'b0, '0, ordy, clr);
  endtask

  // Advances one clock and updates the reference.
  task automatic tick();
    logic acc, dlv;
    item_t it;
    acc = in_valid && exp_ready && rst_n;
    dlv = exp_valid && out_ready && rst_n;
    it  = ref_cmp(in_a, in_b, in_op, in_signed, in_tag);
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (cnt_clr) cnt_m = 0;
      else if (dlv && q[0].res && cnt_m < CNT_MAX) cnt_m++;
      if (dlv) void'(q.pop_front());
      if (acc) begin
        it.k = cyc;
        q.push_back(it);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    q.delete();
    cnt_m = 0;
    idle(1'b1, 1'b0);
    vec++;
    if (obs_vec !== exp_vec) begin
      miscmp++;
      $display("FAIL reset got=%h exp=%h", obs_vec, exp_vec);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_signedness();
    logic [N-1:0] a;
    a = '1;
    for (int c = 0; c < 5; c++) begin
      if (c < 2) drive(1'b1, a, N'(1), 3'd2, (c == 0), TAG_W'(c + 1), 1'b1, 1'b0);
      else idle(1'b1, 1'b0);
      vec++;
      if (obs_vec !== exp_vec) begin
        miscmp++;
        $display("FAIL signedness c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
      tick();
    end
  endtask

  task automatic test_all_ops();
    for (int c = 0; c < 12; c++) begin
      if (c < 6) drive(1'b1, N'(16'h155), N'(16'h155), 3'(c), c[0], TAG_W'(c), 1'b1, 1'b0);
      else if (c == 6) drive(1'b1, N'(0), N'(16'h200), 3'd4, 1'b1, TAG_W'(6), 1'b1, 1'b0);
      else if (c == 7) drive(1'b1, N'(0), N'(16'h200), 3'd2, 1'b1, TAG_W'(7), 1'b1, 1'b0);
      else if (c == 8) drive(1'b1, N'($urandom), N'($urandom), 3'd7, 1'b1, TAG_W'(10), 1'b1, 1'b0);
      else idle(1'b1, 1'b0);
      vec++;
      if (obs_vec !== exp_vec) begin
        miscmp++;
        $display("FAIL all_ops c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 11; c++) begin
      if (c < 8) drive(1'b1, N'($urandom), N'($urandom), 3'($urandom_range(0, 5)),
                       1'($urandom), TAG_W'(c), 1'b1, 1'b0);
      else idle(1'b1, 1'b0);
      vec++;
      if (obs_vec !== exp_vec) begin
        miscmp++;
        $display("FAIL back_to_back c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] a_arr [8];
    logic [N-1:0] b_arr [8];
    logic [2:0]   op_arr[8];
    logic         acc;
    int i, c;
    for (int j = 0; j < 8; j++) begin
      a_arr[j]  = N'($urandom);
      b_arr[j]  = N'($urandom);
      op_arr[j] = 3'($urandom_range(0, 7));
    end
    i = 0;
    c = 0;
    while ((i < 8 || q.size() > 0) && c < 60) begin
      drive(i < 8, a_arr[i % 8], b_arr[i % 8], op_arr[i % 8], 1'b1, TAG_W'(i),
            !(c >= 2 && c < 7), 1'b0);
      vec++;
      if (obs_vec !== exp_vec) begin
        miscmp++;
        $display("FAIL backpressure c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
      acc = in_valid && exp_ready;
      tick();
      if (acc) i++;
      c++;
    end
    vec++;
    if (c >= 60) begin
      miscmp++;
      $display("FAIL backpressure_timeout pending=%0d required=0", q.size());
    end
  endtask

  task automatic test_counter();
    logic [N-1:0] a;
    idle(1'b1, 1'b1);
    tick();
    for (int c = 0; c < 11; c++) begin
      a = N'($urandom);
      if (c < 9) drive(1'b1, a, a, 3'd0, 1'($urandom), TAG_W'(c), 1'b1, 1'b0);
      else idle(1'b1, 1'b0);
      vec++;
      if (obs_vec !== exp_vec) begin
        miscmp++;
        $display("FAIL counter c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
      tick();
    end
    vec++;
    if (match_cnt !== CNT_W'(CNT_MAX)) begin
      miscmp++;
      $display("FAIL counter_sat got=%0d exp=%0d", match_cnt, CNT_MAX);
    end
    // True result reaches the output in the same cycle as the clear.
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(1'b1, N'(5), N'(5), 3'd0, 1'b0, TAG_W'(3), 1'b1, 1'b0);
      else idle(1'b1, c == 2);
      vec++;
      if (obs_vec !== exp_vec) begin
        miscmp++;
        $display("FAIL counter_clr c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
      tick();
    end
    vec++;
    if (match_cnt !== '0) begin
      miscmp++;
      $display("FAIL counter_clr_final got=%0d exp=0", match_cnt);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 6; c++) begin
      if (c < 2) drive(1'b1, N'(9), N'(3), 3'd4, 1'b0, TAG_W'(c), 1'b1, 1'b0);
      else if (c < 4) drive(1'b1, N'(1), N'(1), 3'd5, 1'b0, TAG_W'(c), 1'b0, 1'b0);
      else idle(1'b0, 1'b0);
      vec++;
      if (obs_vec !== exp_vec) begin
        miscmp++;
        $display("FAIL reset_mid_pre c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
      if (c < 5) tick();
    end
    rst_n = 1'b0;
    q.delete();
    cnt_m = 0;
    idle(1'b0, 1'b0);
    vec++;
    if (obs_vec !== exp_vec) begin
      miscmp++;
      $display("FAIL reset_mid_async got=%h exp=%h", obs_vec, exp_vec);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) drive(1'b1, N'($urandom), N'($urandom), 3'($urandom_range(0, 5)),
                       1'($urandom), TAG_W'(c + 8), 1'b1, 1'b0);
      else idle(1'b1, 1'b0);
      vec++;
      if (obs_vec !== exp_vec) begin
        miscmp++;
        $display("FAIL reset_mid_post c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom), N'($urandom), N'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom), TAG_W'($urandom), 1'($urandom_range(0, 3) != 0),
            $urandom_range(0, 15) == 0);
      vec++;
      if (obs_vec !== exp_vec) begin
        miscmp++;
        $display("FAIL random c=%0d got=%h exp=%h", c, obs_vec, exp_vec);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_signedness();
    test_all_ops();
    test_back_to_back();
    test_backpressure();
    test_counter();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule

// File: doc/cmp_pipe.md
# cmp_pipe

Pipelined, parametrised compare unit for the debug queue. Each accepted operand pair (A, B) is compared according to a per-transaction operation code and signedness flag. The 1-bit result and an echoed tag are returned two cycles later over a valid/ready handshake, with full backpressure. A saturating counter records how many delivered results were true, for queue-pointer and occupancy debug.

## Interface
- N, 10, operand width (≥2)
- TAG_W, 4, width of the sideband tag carried alongside each transaction (≥1)
- CNT_W, 16, width of the saturating match counter
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  operand pair present
- in_ready  out  1  unit can accept this cycle
- in_a  in  N  operand A
- in_b  in  N  operand B
- in_op  in  3  000 EQ, 001 NE, 010 LT, 011 GE, 100 GT, 101 LE, 110/111 illegal
- in_signed  in  1  1 = two's-complement compare, 0 = unsigned
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- out_result  out  1  comparison outcome (A op B)
- out_err  out  1  illegal op code; out_result forced 0
- out_tag  out  TAG_W  tag of the transaction
- cnt_clr  in  1  synchronous clear of match_cnt
- match_cnt  out  CNT_W  count of delivered true results, saturating

## Operation
- Input accept: in_valid && in_ready. Output delivery: out_valid && out_ready.
- Stage 1 (S1) on accept:
  - Extend both operands to N+1 bits: sign-extend if in_signed, else zero-extend.
  - Compute D = A_ext − B_ext (N+1 bits).
  - Register eq = (D == 0) and lt = D[N], plus op, tag, and an S1 valid bit.
- Stage 2 (S2), decode from eq/lt:
  - EQ = eq; NE = ~eq; LT = lt; GE = ~lt; GT = ~lt & ~eq; LE = lt | eq.
  - Op 110/111: result 0, err 1. Legal ops: err 0.
  - S2 registers result, err, tag, and an S2 valid bit; these drive the out_* ports directly.
- Pipeline advance rules:
  - S2 loads when S1 valid and (S2 empty or output delivered).
  - S1 loads when in_valid and in_ready.
  - in_ready = ~S1_valid | S2 loads this cycle.
  - Valids clear when their contents move on and nothing replaces them.
- Stall: while out_valid && !out_ready, S2 holds all outputs stable. S1 holds as well if it is full. No transaction is dropped or duplicated.
- match_cnt:
  - +1 on each delivery with out_result = 1.
  - Holds at 2^CNT_W − 1; no wrap.
  - cnt_clr forces 0 next cycle and has priority over a simultaneous increment.
- Reset (asserted at any time, including mid-transaction):
  - S1/S2 valids, out_valid, out_result, out_err, out_tag and match_cnt go to 0 immediately.
  - in_ready is 1 after reset.
  - In-flight transactions are discarded.

## Timing
- Latency: pair accepted at edge k → out_valid high after edge k+1 (S1 at k, S2 at k+1). Result visible in the cycle following edge k+1 (two register stages).
- Throughput: one transaction per cycle while out_ready = 1; no bubbles.
- Capacity: 2 transactions in flight. With out_ready held 0, in_ready falls after the second accept.
- in_ready depends combinationally on out_ready. out_* outputs are registered only.
- Deassertion of rst_n is sampled synchronously to clk.

## Test plan
- Signedness, N=10: A=0x3FF, B=0x001, op LT.
  - in_signed=1 → result 1 (−1 < 1).
  - in_signed=0 → result 0 (1023 > 1).
  - Both delivered 2 cycles after accept.
- All six ops on A=B=0x155 (results 1,0,0,1,0,1), then on A=0x000, B=0x200 signed (−512): GT=1, LT=0. Illegal op 111 → result 0, err 1, tag echoed.
- Back-to-back stream of 8 pairs with out_ready=1 → 8 results in order, one per cycle, tags 0..7 match, in_ready stays 1.
- Backpressure: out_ready=0 for 5 cycles during a stream.
  - in_ready drops after 2 accepts.
  - out_* stable throughout.
  - After release, order is preserved and no loss or duplication occurs.
- Counter, CNT_W=3: 9 true deliveries → match_cnt saturates at 7. cnt_clr coinciding with a true delivery → match_cnt = 0.
- Reset mid-stream with 2 transactions in flight → out_valid=0 and match_cnt=0 at once, in_ready=1. After release, the first new pair emerges with 2-cycle latency and no stale data.
